// File: rtl/coop_pkt_rx.sv
// Packet receiver: SYNC_BYTE, PAYLOAD_BYTES payload bytes, then an XOR checksum byte.
// Drains the UART RX FIFO every cycle and abandons packets on inter-byte timeout.
module coop_pkt_rx #(
    parameter int          PAYLOAD_BYTES  = 3,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_empty,
    output logic                       rx_rd,
    output logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       pkt_valid,
    output logic                       chk_err,
    output logic                       timeout_err,
    output logic [15:0]                pkt_cnt,
    output logic [15:0]                err_cnt
);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        READ_PAYLOAD,
        READ_CHK
    } state_t;

    localparam int          W        = 8 * PAYLOAD_BYTES;
    localparam logic [3:0]  LAST_IDX = 4'(PAYLOAD_BYTES - 1);
    localparam logic [23:0] IDLE_MAX = 24'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [3:0]    idx;
    logic [7:0]    chk;
    logic [23:0]   idle;
    logic [W-1:0]  shadow;
    logic          pop;

    assign pop   = ~rx_empty;
    assign rx_rd = rst_n & ~rx_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_SYNC;
            idx         <= '0;
            chk         <= '0;
            idle        <= '0;
            shadow      <= '0;
            payload     <= '0;
            pkt_valid   <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            pkt_cnt     <= '0;
            err_cnt     <= '0;
        end else begin
            pkt_valid   <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                WAIT_SYNC: begin
                    if (pop && rx_data == SYNC_BYTE) begin
                        state <= READ_PAYLOAD;
                        idx   <= '0;
                        chk   <= '0;
                        idle  <= '0;
                    end
                end
                READ_PAYLOAD, READ_CHK: begin
                    // A byte present on the would-be timeout cycle takes priority.
                    if (pop) begin
                        idle <= '0;
                        if (state == READ_PAYLOAD) begin
                            for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
                                if (idx == 4'(i)) shadow[i*8 +: 8] <= rx_data;
                            end
                            chk <= chk ^ rx_data;
                            idx <= idx + 4'd1;
                            if (idx == LAST_IDX) state <= READ_CHK;
                        end else begin
                            if (rx_data == chk) begin
                                payload   <= shadow;
                                pkt_valid <= 1'b1;
                                pkt_cnt   <= pkt_cnt + 16'd1;
                            end else begin
                                chk_err <= 1'b1;
                                err_cnt <= err_cnt + 16'd1;
                            end
                            state <= WAIT_SYNC;
                        end
                    end else if (idle == IDLE_MAX) begin
                        state       <= WAIT_SYNC;
                        shadow      <= '0;
                        idle        <= '0;
                        timeout_err <= 1'b1;
                        err_cnt     <= err_cnt + 16'd1;
                    end else begin
                        idle <= idle + 24'd1;
                    end
                end
                default: state <= WAIT_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_coop_pkt_rx.sv
// Randomized bench for coop_pkt_rx against a byte-stream packet model.
module tb_coop_pkt_rx;

    localparam int         P    = 3;
    localparam int         TO   = 16;
    localparam logic [7:0] SYNC = 8'hAA;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     rx_data = '0;
    logic           rx_empty = 1'b1;
    logic           rx_rd;
    logic [8*P-1:0] payload;
    logic           pkt_valid, chk_err, timeout_err;
    logic [15:0]    pkt_cnt, err_cnt;

    coop_pkt_rx #(.PAYLOAD_BYTES(P), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_empty(rx_empty), .rx_rd(rx_rd),
        .payload(payload), .pkt_valid(pkt_valid), .chk_err(chk_err),
        .timeout_err(timeout_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a packet is the list of bytes seen since SYNC; a timeout is TO consecutive empty cycles.
    bit             m_in;
    logic [7:0]     m_q[$];
    int             m_idle;
    logic [8*P-1:0] e_payload;
    logic           e_valid, e_chk, e_to;
    logic [15:0]    e_pcnt, e_ecnt;

    task automatic model_reset();
        m_in = 0; m_q.delete(); m_idle = 0;
        e_payload = '0; e_valid = 0; e_chk = 0; e_to = 0; e_pcnt = '0; e_ecnt = '0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d);
        logic [7:0] x;
        e_valid = 0; e_chk = 0; e_to = 0;
        if (!m_in) begin
            if (v && d == SYNC) begin
                m_in = 1; m_q.delete(); m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            if (m_q.size() < P) begin
                m_q.push_back(d);
            end else begin
                x = '0;
                foreach (m_q[k]) x = x ^ m_q[k];
                if (x == d) begin
                    for (int unsigned i = 0; i < P; i++) e_payload[i*8 +: 8] = m_q[i];
                    e_valid = 1; e_pcnt = e_pcnt + 16'd1;
                end else begin
                    e_chk = 1; e_ecnt = e_ecnt + 16'd1;
                end
                m_in = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_in = 0; e_to = 1; e_ecnt = e_ecnt + 16'd1;
            end
        end
    endtask

    task automatic check_outputs();
        check("payload", 64'(payload), 64'(e_payload));
        check("pkt_valid", 64'(pkt_valid), 64'(e_valid));
        check("chk_err", 64'(chk_err), 64'(e_chk));
        check("timeout_err", 64'(timeout_err), 64'(e_to));
        check("pkt_cnt", 64'(pkt_cnt), 64'(e_pcnt));
        check("err_cnt", 64'(err_cnt), 64'(e_ecnt));
    endtask

    task automatic cyc(input bit v, input logic [7:0] d);
        @(negedge clk);
        rx_empty = !v;
        rx_data  = v ? d : 8'($urandom);
        #1 check("rx_rd", 64'(rx_rd), 64'(v));
        @(posedge clk);
        model_step(v, d);
        #1 check_outputs();
    endtask

    task automatic send(input logic [7:0] b[$]);
        foreach (b[k]) cyc(1'b1, b[k]);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rx_empty = 1'b0; rx_data = SYNC;
        #1 check("rx_rd_in_reset", 64'(rx_rd), 64'd0);
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1; rx_empty = 1'b1;
    endtask

    task automatic rand_packet(input bit good);
        logic [7:0] x;
        logic [7:0] b;
        cyc(1'b1, SYNC);
        x = '0;
        for (int i = 0; i < P + 1; i++) begin
            if ($urandom_range(0, 9) == 0) idle_n($urandom_range(TO - 2, TO + 1));
            else if ($urandom_range(0, 3) == 0) idle_n($urandom_range(1, 3));
            if (i < P) begin
                b = ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom);
                x = x ^ b;
            end else begin
                b = good ? x : (x ^ 8'(1 << $urandom_range(0, 7)));
            end
            cyc(1'b1, b);
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        send('{8'hAA, 8'h34, 8'h12, 8'h56, 8'h70});
        check("good_payload", 64'(payload), 64'h561234);
        check("good_pkt_cnt", 64'(pkt_cnt), 64'd1);
        send('{8'hAA, 8'h01, 8'h02, 8'h03, 8'hFF});
        check("bad_payload_kept", 64'(payload), 64'h561234);
        check("bad_err_cnt", 64'(err_cnt), 64'd1);
        idle_n(2);

        do_reset();
        send('{8'h00, 8'h55, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'hAA});
        check("garbage_payload", 64'(payload), 64'h0000AA);
        check("garbage_pkt_cnt", 64'(pkt_cnt), 64'd1);

        do_reset();
        send('{8'hAA, 8'h11});
        idle_n(TO);
        check("timeout_err_cnt", 64'(err_cnt), 64'd1);
        send('{8'hAA, 8'h01, 8'h02, 8'h03, 8'h00});
        check("after_timeout_payload", 64'(payload), 64'h030201);

        do_reset();
        send('{8'hAA, 8'h11});
        idle_n(TO - 1);
        send('{8'h22, 8'h33, 8'h00});
        check("boundary_payload", 64'(payload), 64'h332211);
        check("boundary_err_cnt", 64'(err_cnt), 64'd0);

        do_reset();
        send('{8'hAA, 8'h11, 8'h22});
        do_reset();
        send('{8'h33, 8'h44, 8'h55, 8'h66, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h00});
        check("rst_mid_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("rst_mid_err_cnt", 64'(err_cnt), 64'd0);

        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0:       cyc(1'b1, 8'($urandom));
                1:       idle_n($urandom_range(0, 5));
                2:       rand_packet(1'b0);
                3: begin
                    cyc(1'b1, SYNC);
                    idle_n($urandom_range(TO - 1, TO));
                end
                4:       if ($urandom_range(0, 3) == 0) do_reset(); else rand_packet(1'b1);
                default: rand_packet(1'b1);
            endcase
        end
        idle_n(TO + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
